// File: rtl/round_sequencer.sv
// round_sequencer
// Sequences one game round: countdown, wall approach, pose check, result
// display, then back to idle. Game time comes from a one-cycle tick strobe;
// MS_PER_SEC ticks make one second of game time.
//
// Ports
//   clk_in          system clock, all state on its rising edge
//   rst_in          asynchronous active-low reset
//   tick_in         1 ms strobe, one cycle wide
//   start_in        start-round request pulse (honoured in IDLE only)
//   abort_in        abandon the current round (wins over every other input)
//   check_done_in   pose-checker verdict valid (honoured in CHECK only)
//   check_pass_in   pose-checker verdict, sampled with check_done_in
//   phase_out       0 IDLE, 1 COUNTDOWN, 2 APPROACH, 3 CHECK, 4 RESULT
//   sec_left_out    whole seconds remaining in the current timed phase
//   approach_ms_out ticks elapsed in APPROACH (wall position), 0 elsewhere
//   check_req_out   high exactly while in CHECK
//   pass_out        latched verdict of the last completed check
//   round_done_out  one-cycle pulse when RESULT expires back to IDLE
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for start_in; pass_out holds last verdict
// COUNTDOWN | pre-round countdown, COUNTDOWN_S seconds
// APPROACH  | wall approaching, APPROACH_S seconds, approach_ms_out counts
// CHECK     | untimed; waiting for the pose checker verdict
// RESULT    | verdict shown for RESULT_S seconds, then round_done_out

module round_sequencer #(
    parameter int MS_PER_SEC  = 1000,
    parameter int COUNTDOWN_S = 3,
    parameter int APPROACH_S  = 5,
    parameter int RESULT_S    = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        tick_in,
    input  logic        start_in,
    input  logic        abort_in,
    input  logic        check_done_in,
    input  logic        check_pass_in,
    output logic [2:0]  phase_out,
    output logic [3:0]  sec_left_out,
    output logic [15:0] approach_ms_out,
    output logic        check_req_out,
    output logic        pass_out,
    output logic        round_done_out
);

    localparam int MS_W = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;
    localparam logic [MS_W-1:0] MS_LAST = MS_W'(MS_PER_SEC - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_APPROACH  = 3'd2,
        ST_CHECK     = 3'd3,
        ST_RESULT    = 3'd4
    } phase_t;

    phase_t          r_phase;
    logic [MS_W-1:0] r_ms;
    logic [3:0]      r_sec;
    logic [15:0]     r_approach_ms;
    logic            r_pass;
    logic            r_done;

    phase_t          w_phase_nxt;
    logic [MS_W-1:0] w_ms_nxt;
    logic [3:0]      w_sec_nxt;
    logic [15:0]     w_approach_ms_nxt;
    logic            w_pass_nxt;
    logic            w_done_nxt;
    logic            w_timed;
    logic            w_sec_edge;

    // Only the three timed phases consume ticks.
    assign w_timed    = (r_phase == ST_COUNTDOWN) || (r_phase == ST_APPROACH) ||
                        (r_phase == ST_RESULT);
    assign w_sec_edge = w_timed && tick_in && (r_ms == MS_LAST);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_phase       <= ST_IDLE;
            r_ms          <= '0;
            r_sec         <= '0;
            r_approach_ms <= '0;
            r_pass        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_phase       <= w_phase_nxt;
            r_ms          <= w_ms_nxt;
            r_sec         <= w_sec_nxt;
            r_approach_ms <= w_approach_ms_nxt;
            r_pass        <= w_pass_nxt;
            r_done        <= w_done_nxt;
        end
    end

    always_comb begin
        w_phase_nxt       = r_phase;
        w_ms_nxt          = r_ms;
        w_sec_nxt         = r_sec;
        w_approach_ms_nxt = r_approach_ms;
        w_pass_nxt        = r_pass;
        w_done_nxt        = 1'b0;

        if (abort_in && (r_phase != ST_IDLE)) begin
            // Abort wipes the round, including the verdict, and never
            // produces a completion pulse.
            w_phase_nxt       = ST_IDLE;
            w_ms_nxt          = '0;
            w_sec_nxt         = '0;
            w_approach_ms_nxt = '0;
            w_pass_nxt        = 1'b0;
        end else begin
            case (r_phase)
                ST_IDLE: begin
                    if (start_in && !abort_in) begin
                        w_phase_nxt       = ST_COUNTDOWN;
                        w_ms_nxt          = '0;
                        w_sec_nxt         = 4'(COUNTDOWN_S);
                        w_approach_ms_nxt = '0;
                        w_pass_nxt        = 1'b0;
                    end
                end

                ST_CHECK: begin
                    if (check_done_in) begin
                        w_phase_nxt = ST_RESULT;
                        w_pass_nxt  = check_pass_in;
                        w_sec_nxt   = 4'(RESULT_S);
                        w_ms_nxt    = '0;
                    end
                end

                ST_COUNTDOWN, ST_APPROACH, ST_RESULT: begin
                    if (tick_in) begin
                        if (r_phase == ST_APPROACH) begin
                            w_approach_ms_nxt = r_approach_ms + 16'd1;
                        end
                        if (w_sec_edge) begin
                            w_ms_nxt = '0;
                            if (r_sec == 4'd1) begin
                                // Last second expired: advance instead of
                                // counting down to zero.
                                case (r_phase)
                                    ST_COUNTDOWN: begin
                                        w_phase_nxt       = ST_APPROACH;
                                        w_sec_nxt         = 4'(APPROACH_S);
                                        w_approach_ms_nxt = '0;
                                    end
                                    ST_APPROACH: begin
                                        w_phase_nxt       = ST_CHECK;
                                        w_sec_nxt         = '0;
                                        w_approach_ms_nxt = '0;
                                    end
                                    default: begin
                                        w_phase_nxt = ST_IDLE;
                                        w_sec_nxt   = '0;
                                        w_done_nxt  = 1'b1;
                                    end
                                endcase
                            end else begin
                                w_sec_nxt = r_sec - 4'd1;
                            end
                        end else begin
                            w_ms_nxt = r_ms + MS_W'(1);
                        end
                    end
                end

                default: begin
                    w_phase_nxt       = ST_IDLE;
                    w_ms_nxt          = '0;
                    w_sec_nxt         = '0;
                    w_approach_ms_nxt = '0;
                    w_pass_nxt        = 1'b0;
                end
            endcase
        end
    end

    assign phase_out       = r_phase;
    assign sec_left_out    = r_sec;
    assign approach_ms_out = r_approach_ms;
    assign check_req_out   = (r_phase == ST_CHECK);
    assign pass_out        = r_pass;
    assign round_done_out  = r_done;

endmodule
